// File: rtl/clk_div_n_if.sv
// rtl/clk_div_n_if.sv - control/status bundle of the programmable clock divider
//
// Purpose: groups the run request, ratio and divided-clock outputs of clk_div_n.
// Signals:
//   div_en     master->slave  run request, sampled on posedge clk_in
//   div_ratio  master->slave  requested ratio N (W bits)
//   clk_out    slave->master  divided clock, 50% duty
//   div_tick   slave->master  one-cycle pulse in the cycle clk_out period starts
//   ratio_err  slave->master  sticky flag: a ratio of 0 or 1 was loaded
//   busy       slave->master  divider running
`timescale 1ns/1ps

interface clk_div_n_if #(
    parameter int W = 4
) ();
    logic         div_en;
    logic [W-1:0] div_ratio;
    logic         clk_out;
    logic         div_tick;
    logic         ratio_err;
    logic         busy;

    modport master (
        output div_en,
        output div_ratio,
        input  clk_out,
        input  div_tick,
        input  ratio_err,
        input  busy
    );

    modport slave (
        input  div_en,
        input  div_ratio,
        output clk_out,
        output div_tick,
        output ratio_err,
        output busy
    );
endinterface

// File: rtl/clk_div_n.sv
// rtl/clk_div_n.sv - programmable integer clock divider, 50% duty for even and odd ratios
//
// Purpose: divides clk_in by a run-time ratio N (2..2**W-1). Ratio changes and
// start/stop are only honoured on an output-period boundary, so the output never
// carries a runt pulse.
// Ports:
//   clk_in   in   source clock (both edges used)
//   rst_n    in   asynchronous active-low reset, released synchronously to posedge clk_in
//   dif      slave modport of clk_div_n_if (div_en, div_ratio in; clk_out, div_tick,
//            ratio_err, busy out)
`timescale 1ns/1ps

module clk_div_n #(
    parameter int W         = 4,
    parameter int RST_RATIO = 3
) (
    input  logic        clk_in,
    input  logic        rst_n,
    clk_div_n_if.slave  dif
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t       state_q, state_d;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] n_act_q, n_act_d;
    logic         pos_q, pos_d;
    logic         pe_q, pe_d;
    logic         neg_q;
    logic         tick_q, tick_d;
    logic         err_q, err_d;

    logic         load;
    logic         wrap;
    logic         ratio_low;
    logic [W-1:0] ratio_ld;
    logic [W:0]   half_d;

    // Ratios below 2 cannot produce a 50% clock; they run as 2 and flag an error.
    assign ratio_low = (dif.div_ratio < W'(2));
    assign ratio_ld  = ratio_low ? W'(2) : dif.div_ratio;
    assign wrap      = (cnt_q == (n_act_q - W'(1)));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        n_act_d = n_act_q;
        err_d   = err_q;
        load    = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (dif.div_en) begin
                    load    = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (wrap) begin
                    cnt_d = '0;
                    if (dif.div_en) begin
                        load = 1'b1;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        if (load) begin
            n_act_d = ratio_ld;
            if (ratio_low) begin
                err_d = 1'b1;
            end
        end
    end

    // ceil(N/2) computed one bit wider so N = 2**W-1 does not overflow.
    assign half_d = ({1'b0, n_act_d} + (W+1)'(1)) >> 1;

    // pos_q is high for the first ceil(N/2) counts of each period.
    // pe_q is the same waveform, but only for even ratios: it lets the even path
    // bypass the negedge stage without a select that switches at the same edge
    // pos_q rises (which would be a glitch hazard on odd-after-even reloads).
    always_comb begin
        pos_d  = (state_d == S_RUN) && ({1'b0, cnt_d} < half_d);
        pe_d   = pos_d && !n_act_d[0];
        tick_d = (state_d == S_RUN) && (cnt_d == '0);
    end

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            n_act_q <= W'(RST_RATIO);
            pos_q   <= 1'b0;
            pe_q    <= 1'b0;
            tick_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_act_q <= n_act_d;
            pos_q   <= pos_d;
            pe_q    <= pe_d;
            tick_q  <= tick_d;
            err_q   <= err_d;
        end
    end

    // Half-cycle retimed copy of pos_q; ANDing it with pos_q trims half a cycle
    // off the leading edge, giving exactly N/2 high time for odd N.
    always_ff @(negedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= pos_q;
        end
    end

    // Even N: pe_q alone (pos_q & neg_q lies inside it). Odd N: pe_q is 0.
    // Every term is a flop output, and no two inputs of the gate change in
    // opposite directions on the same edge.
    assign dif.clk_out   = pe_q | (pos_q & neg_q);
    assign dif.div_tick  = tick_q;
    assign dif.ratio_err = err_q;
    assign dif.busy      = (state_q == S_RUN);

endmodule

// File: tb/tb_clk_div_n.sv
// tb/tb_clk_div_n.sv - self-checking bench for clk_div_n
`timescale 1ns/1ps

module tb_clk_div_n;

    logic clk_in = 1'b0;
    logic rst_n;

    clk_div_n_if #(.W(4)) dif ();

    clk_div_n #(.W(4), .RST_RATIO(3)) dut (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .dif    (dif)
    );

    always #5 clk_in = ~clk_in;

    int     vectors = 0;
    int     errors  = 0;

    // Reference model: a period of N cycles starts at a posedge; clk_out is
    // high for N half-cycles, starting half a cycle late when N is odd.
    bit     m_run;
    bit     m_err;
    int     m_n;
    int     m_pos;

    int     rise_cnt = 0;
    longint t_rise = 0;
    longint t_rise_prev = 0;
    longint hi_ps = 0;
    longint t_pos = 0;
    bit     last_tick;
    bit     last_busy;
    int     tick_cnt = 0;

    function automatic longint now_ps();
        return longint'($realtime * 1000.0);
    endfunction

    always @(posedge dif.clk_out) begin
        t_rise_prev = t_rise;
        t_rise      = now_ps();
        rise_cnt    = rise_cnt + 1;
    end

    always @(negedge dif.clk_out) begin
        hi_ps = now_ps() - t_rise;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors = vectors + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_run = 1'b0;
        m_err = 1'b0;
        m_n   = 2;
        m_pos = 0;
    endfunction

    function automatic void model_start();
        int r;
        r = int'(dif.div_ratio);
        if (r < 2) begin
            m_err = 1'b1;
            m_n   = 2;
        end else begin
            m_n = r;
        end
        m_run = 1'b1;
        m_pos = 0;
    endfunction

    function automatic void model_edge();
        if (!rst_n) begin
            model_reset();
        end else if (!m_run) begin
            if (dif.div_en) model_start();
        end else begin
            m_pos = m_pos + 1;
            if (m_pos == m_n) begin
                if (dif.div_en) begin
                    model_start();
                end else begin
                    m_run = 1'b0;
                    m_pos = 0;
                end
            end
        end
    endfunction

    task automatic compare(input int half);
        int       h;
        int       first;
        logic [3:0] exp_v;
        logic [3:0] act_v;
        if (!rst_n) model_reset();
        h     = 2 * m_pos + half;
        first = m_n % 2;
        exp_v = {m_run && (h >= first) && (h < first + m_n),
                 m_run && (m_pos == 0), m_err, m_run};
        act_v = {dif.clk_out, dif.div_tick, dif.ratio_err, dif.busy};
        chk(half != 0 ? "outputs after negedge" : "outputs after posedge",
            64'(act_v), 64'(exp_v));
    endtask

    // One clk_in cycle; returns at negedge+2, where inputs are driven.
    task automatic cycle();
        @(posedge clk_in);
        t_pos = now_ps();
        model_edge();
        #1;
        compare(0);
        last_tick = dif.div_tick;
        last_busy = dif.busy;
        if (dif.div_tick) tick_cnt = tick_cnt + 1;
        @(negedge clk_in);
        #1;
        compare(1);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic wait_tick(output int n);
        n = 0;
        for (int i = 0; i < 40; i++) begin
            cycle();
            n = n + 1;
            if (last_tick) break;
        end
        chk("tick seen", 64'(last_tick), 64'd1);
    endtask

    initial begin
        int r0;
        int t0;
        int n;

        model_reset();
        rst_n         = 1'b0;
        dif.div_en    = 1'b0;
        dif.div_ratio = 4'd4;
        run(3);
        chk("reset outputs", 64'({dif.clk_out, dif.div_tick, dif.ratio_err, dif.busy}), 64'd0);
        rst_n = 1'b1;
        run(2);

        // N=4 from idle: rise one posedge after div_en, period 4T, high 2T.
        dif.div_en = 1'b1;
        r0 = rise_cnt;
        cycle();
        chk("n4 first rise count", 64'(rise_cnt - r0), 64'd1);
        chk("n4 first rise time", 64'(t_rise), 64'(t_pos));
        run(11);
        chk("n4 period ps", 64'(t_rise - t_rise_prev), 64'd40000);
        chk("n4 high ps", 64'(hi_ps), 64'd20000);
        t0 = tick_cnt;
        run(12);
        chk("n4 ticks in 12", 64'(tick_cnt - t0), 64'd3);

        // Odd ratios and maximum ratio.
        dif.div_ratio = 4'd3;
        run(16);
        chk("n3 period ps", 64'(t_rise - t_rise_prev), 64'd30000);
        chk("n3 high ps", 64'(hi_ps), 64'd15000);
        dif.div_ratio = 4'd5;
        run(20);
        chk("n5 period ps", 64'(t_rise - t_rise_prev), 64'd50000);
        chk("n5 high ps", 64'(hi_ps), 64'd25000);
        dif.div_ratio = 4'd15;
        run(50);
        chk("n15 period ps", 64'(t_rise - t_rise_prev), 64'd150000);
        chk("n15 high ps", 64'(hi_ps), 64'd75000);

        // Ratio 4->7 requested at cnt=1: current period stays 4, next is 7.
        dif.div_ratio = 4'd4;
        run(20);
        wait_tick(n);
        cycle();
        dif.div_ratio = 4'd7;
        wait_tick(n);
        chk("4to7 old period cycles", 64'(n + 1), 64'd4);
        wait_tick(n);
        chk("4to7 new period cycles", 64'(n), 64'd7);
        chk("n7 period ps", 64'(t_rise - t_rise_prev), 64'd70000);
        chk("n7 high ps", 64'(hi_ps), 64'd35000);

        // Ratios 1 and 0 run as 2 and set the sticky error.
        dif.div_ratio = 4'd1;
        run(14);
        chk("r1 period ps", 64'(t_rise - t_rise_prev), 64'd20000);
        chk("r1 high ps", 64'(hi_ps), 64'd10000);
        chk("r1 ratio_err", 64'(dif.ratio_err), 64'd1);
        dif.div_ratio = 4'd0;
        run(6);
        chk("r0 period ps", 64'(t_rise - t_rise_prev), 64'd20000);
        chk("r0 ratio_err", 64'(dif.ratio_err), 64'd1);

        // Disable mid-period with N=6: the period completes, then stops.
        dif.div_ratio = 4'd6;
        wait_tick(n);
        wait_tick(n);
        chk("n6 period cycles", 64'(n), 64'd6);
        run(2);
        dif.div_en = 1'b0;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            n = n + 1;
            if (!last_busy) break;
        end
        chk("stop cycles to idle", 64'(n), 64'd4);
        chk("stop last high ps", 64'(hi_ps), 64'd30000);
        r0 = rise_cnt;
        run(5);
        chk("stopped no rises", 64'(rise_cnt - r0), 64'd0);
        dif.div_ratio = 4'd5;
        dif.div_en    = 1'b1;
        cycle();
        chk("restart rise count", 64'(rise_cnt - r0), 64'd1);
        run(12);
        chk("restart period ps", 64'(t_rise - t_rise_prev), 64'd50000);
        chk("restart high ps", 64'(hi_ps), 64'd25000);

        // Reset asserted in the high phase: clk_out drops at once.
        dif.div_ratio = 4'd4;
        run(12);
        for (int i = 0; i < 20; i++) begin
            if (dif.clk_out) break;
            cycle();
        end
        chk("pre-reset clk_out high", 64'(dif.clk_out), 64'd1);
        chk("pre-reset ratio_err", 64'(dif.ratio_err), 64'd1);
        rst_n = 1'b0;
        #0.001;
        chk("async reset outputs", 64'({dif.clk_out, dif.div_tick, dif.busy}), 64'd0);
        run(2);
        chk("reset clears ratio_err", 64'(dif.ratio_err), 64'd0);
        rst_n = 1'b1;
        r0 = rise_cnt;
        cycle();
        chk("post-reset rise count", 64'(rise_cnt - r0), 64'd1);
        chk("post-reset rise time", 64'(t_rise), 64'(t_pos));

        // Randomized traffic against the model.
        for (int i = 0; i < 1500; i++) begin
            if ($urandom % 8 == 0) dif.div_ratio = 4'($urandom % 16);
            dif.div_en = ($urandom % 12) != 0;
            rst_n      = ($urandom % 400) != 0;
            cycle();
        end
        rst_n = 1'b1;
        run(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
